alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 164 ++++++++++++++++
 tb/tb_alu_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU. Non-shift ops have 1-cycle latency; shifts move one bit per cycle.
// Define ALU_PIPE_OVF_EN to add the signed-overflow output OF for add/sub.
module alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       opcode,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] fin,
    output logic             Co,
    output logic             CF,
    output logic             ZF
`ifdef ALU_PIPE_OVF_EN
    ,
    output logic             OF
`endif
);

    localparam int unsigned      CntW    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] WidthOp = WIDTH'(WIDTH);
    localparam logic [CntW-1:0]  CntMax  = CntW'(WIDTH);
    localparam logic [CntW-1:0]  CntOne  = CntW'(1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpGt  = 3'b101;
    localparam logic [2:0] OpShl = 3'b110;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] fin_q, fin_d;
    logic             co_q, co_d;
    logic             cf_q, cf_d;
    logic             dir_q, dir_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             accept;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH:0]   sum;
    logic [CntW-1:0]  amt;

`ifdef ALU_PIPE_OVF_EN
    logic of_q, of_d;
    logic ovf;
    // Signed overflow: operands share a sign that the result does not.
    assign ovf = (A[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign OF  = of_q;
`endif

    assign in_ready = rst_n && ((state_q == StIdle) || ((state_q == StHold) && out_ready));
    assign accept   = in_valid && in_ready;

    assign b_op = (opcode == OpSub) ? ~B : B;
    assign sum  = {1'b0, A} + {1'b0, b_op} + {{WIDTH{1'b0}}, ci};
    // Amounts beyond WIDTH shift everything out, so clamp to keep the counter small.
    assign amt  = (B >= WidthOp) ? CntMax : CntW'(B);

    always_comb begin
        state_d = state_q;
        fin_d   = fin_q;
        co_d    = co_q;
        cf_d    = cf_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
`ifdef ALU_PIPE_OVF_EN
        of_d    = of_q;
`endif
        unique case (state_q)
            StIdle, StHold: begin
                if (accept) begin
                    state_d = StHold;
                    co_d    = 1'b0;
                    cf_d    = 1'b0;
`ifdef ALU_PIPE_OVF_EN
                    of_d    = 1'b0;
`endif
                    unique case (opcode)
                        OpAdd, OpSub: begin
                            fin_d = sum[WIDTH-1:0];
                            co_d  = sum[WIDTH];
                            cf_d  = sum[WIDTH];
`ifdef ALU_PIPE_OVF_EN
                            of_d  = ovf;
`endif
                        end
                        OpAnd:   fin_d = A & B;
                        OpOr:    fin_d = A | B;
                        OpXor:   fin_d = A ^ B;
                        OpGt:    fin_d = {{(WIDTH-1){1'b0}}, (A > B)};
                        default: begin
                            // Shifts: fin doubles as the working register; zero amount is a pass-through.
                            fin_d = A;
                            dir_d = (opcode == OpShl);
                            cnt_d = amt;
                            if (amt != '0) begin
                                state_d = StShift;
                            end
                        end
                    endcase
                end else if ((state_q == StHold) && out_ready) begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                if (dir_q) begin
                    {cf_d, fin_d} = {fin_q, 1'b0};
                end else begin
                    {fin_d, cf_d} = {1'b0, fin_q};
                end
                cnt_d = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StHold;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            fin_q   <= '0;
            co_q    <= 1'b0;
            cf_q    <= 1'b0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef ALU_PIPE_OVF_EN
            of_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            fin_q   <= fin_d;
            co_q    <= co_d;
            cf_q    <= cf_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
`ifdef ALU_PIPE_OVF_EN
            of_q    <= of_d;
`endif
        end
    end

    assign out_valid = (state_q == StHold);
    assign fin       = fin_q;
    assign Co        = co_q;
    assign CF        = cf_q;
    assign ZF        = ~|fin_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and random bundles; expected results queued at acceptance and
// compared by an independent monitor whenever out_valid is high.
module tb_alu_pipe;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [2:0]   opcode = '0;
    logic         ci = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] fin;
    logic         Co, CF, ZF;
`ifdef ALU_PIPE_OVF_EN
    logic         OF;
`endif

    typedef struct {
        int fin;
        int co;
        int cf;
        int ovf;
        int due;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   force_stall = 0;
    bit   rnd_ready = 1'b0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .opcode    (opcode),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fin       (fin),
        .Co        (Co),
        .CF        (CF),
        .ZF        (ZF)
`ifdef ALU_PIPE_OVF_EN
        ,
        .OF        (OF)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= HALF) ? v - (1 << W) : v;
    endfunction

    // Reference: results straight from the arithmetic definitions of each opcode.
    function automatic exp_t model(input int op, input int a, input int b, input int c);
        exp_t e;
        int   s, k, nb;
        e = '{default: 0};
        e.due = 1;
        k = (b > W) ? W : b;
        case (op)
            0, 1: begin
                nb    = (op == 0) ? b : (~b & MASK);
                s     = a + nb + c;
                e.fin = s & MASK;
                e.co  = s >> W;
                e.cf  = e.co;
                s     = sgn(a) + sgn(nb) + c;
                e.ovf = (s >= HALF || s < -HALF) ? 1 : 0;
            end
            2: e.fin = a & b;
            3: e.fin = a | b;
            4: e.fin = a ^ b;
            5: e.fin = (a > b) ? 1 : 0;
            6: begin
                e.fin = (a << k) & MASK;
                e.cf  = (k == 0) ? 0 : (a >> (W - k)) & 1;
                e.due = k + 1;
            end
            default: begin
                e.fin = a >> k;
                e.cf  = (k == 0) ? 0 : (a >> (k - 1)) & 1;
                e.due = k + 1;
            end
        endcase
        return e;
    endfunction

    // Block is free when nothing is outstanding, or the visible result drains this cycle.
    function automatic int exp_ready();
        if (sb.size() == 0) return 1;
        return (cyc >= sb[0].due && out_ready) ? 1 : 0;
    endfunction

    task automatic issue(input int op, input int a, input int b, input int c, input int stall);
        exp_t e;
        bit   done;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        opcode   = op[2:0];
        A        = W'(a);
        B        = W'(b);
        ci       = c[0];
        e        = model(op, a, b, c);
        done     = 1'b0;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            check("in_ready", in_ready, exp_ready());
            if (in_ready) begin
                e.due = e.due + cyc;
                sb.push_back(e);
                if (stall > 0) force_stall = stall;
                done = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (force_stall > 0) begin
                out_ready   = 1'b0;
                force_stall = force_stall - 1;
            end else begin
                out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
        end
    end

    initial begin
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 0);
                end else begin
                    if (!seen) begin
                        check("latency", cyc, sb[0].due);
                        seen = 1'b1;
                    end
                    check("fin", fin, sb[0].fin);
                    check("Co", Co, sb[0].co);
                    check("CF", CF, sb[0].cf);
                    check("ZF", ZF, (sb[0].fin == 0) ? 1 : 0);
`ifdef ALU_PIPE_OVF_EN
                    check("OF", OF, sb[0].ovf);
`endif
                    if (out_ready) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int op, a, b;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_fin", fin, 0);
        check("rst_ZF", ZF, 1);
        @(negedge clk);
        rst_n = 1'b1;

        issue(0, 'hF6, 'h95, 0, 0);
        issue(1, 'hF6, 'h95, 1, 0);
        issue(0, 'h7F, 'h01, 0, 0);
        issue(6, 'hF6, 'h03, 0, 0);
        issue(7, 'hF6, 'h09, 0, 0);
        issue(4, 'hF6, 'h95, 0, 5);
        issue(5, 'h95, 'hF6, 0, 0);
        issue(6, 'h81, 'h00, 0, 0);
        issue(6, 'h81, 'h08, 0, 0);
        issue(7, 'h81, 'h01, 0, 0);
        issue(1, 'h00, 'h01, 0, 0);

        rnd_ready = 1'b1;
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, MASK));
            b  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, W + 2))
                                             : int'($urandom_range(0, MASK));
            issue(op, a, b, int'($urandom_range(0, 1)), 0);
        end
        rnd_ready = 1'b0;
        drain();

        // Reset two cycles into a 7-step shift: the shift must vanish.
        issue(6, 'hFF, 'h07, 0, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_fin", fin, 0);
        check("midrst_Co", Co, 0);
        check("midrst_CF", CF, 0);
        check("midrst_ZF", ZF, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
`ifdef ALU_PIPE_OVF_EN
        check("midrst_OF", OF, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("post_rst_out_valid", out_valid, 0);
        end
        issue(0, 'h01, 'h02, 1, 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
